uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 11 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/uart_tx_arbiter.sv | 104 ++++++++++
 tb/tb_uart_tx_arbiter.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart TX arbiter.
package uart_pkg;

  localparam int unsigned BEAT_CNT_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches upward from last_grant+1, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_PORTS = 4,
  localparam int unsigned ID_W = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [ID_W-1:0]      last_grant,
  output logic [ID_W-1:0]      grant,
  output logic                 any_req
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      int unsigned idx;
      idx = (32'(last_grant) + k) % NUM_PORTS;
      if (!found && req[idx[ID_W-1:0]]) begin
        grant = idx[ID_W-1:0];
        found = 1'b1;
      end
    end
    any_req = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin AXI-Stream mux that hands the uart TX byte path to one requester at a time.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BEATS  = 64,
  localparam int unsigned ID_W = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [ID_W-1:0]                 grant_id,
  output logic                            busy
);

  localparam int unsigned MaxBeatsInt = MAX_BEATS;
  localparam logic [BEAT_CNT_W:0] MaxBeatsW = MaxBeatsInt[BEAT_CNT_W:0];
  localparam int unsigned LastInit = NUM_PORTS - 1;

  arb_state_t            state_q, state_d;
  logic [ID_W-1:0]       grant_q, grant_d;
  logic [ID_W-1:0]       last_q, last_d;
  logic [BEAT_CNT_W-1:0] beat_q, beat_d;

  logic [ID_W-1:0]       rr_grant;
  logic                  rr_any;
  logic                  sel_valid, sel_last, accept, burst_done;
  logic [BEAT_CNT_W:0]   beat_wide;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arbiter (
    .req        (s_axis_tvalid),
    .last_grant (last_q),
    .grant      (rr_grant),
    .any_req    (rr_any)
  );

  assign sel_valid  = s_axis_tvalid[grant_q];
  assign sel_last   = s_axis_tlast[grant_q];
  assign beat_wide  = {1'b0, beat_q} + 1'b1;
  assign burst_done = (beat_wide == MaxBeatsW);

  always_comb begin
    m_axis_tdata  = s_axis_tdata[32'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    m_axis_tvalid = (state_q == GRANT) && sel_valid;
    s_axis_tready = '0;
    if (state_q == GRANT) begin
      s_axis_tready[grant_q] = m_axis_tready;
    end
    accept   = m_axis_tvalid && m_axis_tready;
    busy     = (state_q == GRANT);
    grant_id = grant_q;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (rr_any) begin
          state_d = GRANT;
          grant_d = rr_grant;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (accept) begin
          beat_d = (beat_q == '1) ? beat_q : beat_wide[BEAT_CNT_W-1:0];
          // Releasing owner becomes lowest priority in the next round.
          if (sel_last || burst_done) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= LastInit[ID_W-1:0];
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench: per-port packet queues, transaction-level round-robin model.
module tb_uart_tx_arbiter;

  localparam int NP   = 4;
  localparam int DW   = 8;
  localparam int MAXB = 4;
  localparam int IDW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]    s_tvalid, s_tlast, s_tready;
  logic [DW-1:0]    m_tdata;
  logic             m_tvalid, m_tready;
  logic [IDW-1:0]   grant_id;
  logic             busy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .MAX_BEATS  (MAXB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .grant_id      (grant_id),
    .busy          (busy)
  );

  int tests_run = 0;
  int failed    = 0;

  logic [8:0] src_q [NP][$];   // {tlast, data}
  int         exp_port[$];
  logic [7:0] exp_data[$];
  bit         exp_end[$];
  int         acc_port[$];
  int         model_last;
  int         ready_mode;      // 0 always, 1 toggle, 2 random, 3 never
  bit         drop_en;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_inputs(input int cyc);
    for (int i = 0; i < NP; i++) begin
      if (src_q[i].size() > 0 &&
          !(drop_en && busy && (grant_id == i) && ($urandom_range(0, 3) == 0))) begin
        s_tvalid[i]          = 1'b1;
        s_tdata[i*DW +: DW]  = src_q[i][0][7:0];
        s_tlast[i]           = src_q[i][0][8];
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tdata[i*DW +: DW]  = DW'($urandom);
        s_tlast[i]           = 1'($urandom);
      end
    end
    case (ready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 2 == 0);
      2:       m_tready = 1'($urandom);
      default: m_tready = 1'b0;
    endcase
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    m_tready = 1'b0;
    for (int i = 0; i < NP; i++) src_q[i].delete();
    repeat (2) @(posedge clk);
    #1;
    rst        = 1'b0;
    model_last = NP - 1;
  endtask

  // Expected beat stream from the queued packets: round-robin from last+1,
  // each grant ends at tlast or after MAXB beats.
  task automatic build_model();
    logic [8:0] mq [NP][$];
    int  last;
    exp_port.delete();
    exp_data.delete();
    exp_end.delete();
    for (int i = 0; i < NP; i++) mq[i] = src_q[i];
    last = model_last;
    while (1) begin
      int  p;
      int  cnt;
      bit  done;
      p = -1;
      for (int k = 1; k <= NP; k++) begin
        int c;
        c = (last + k) % NP;
        if (p < 0 && mq[c].size() > 0) p = c;
      end
      if (p < 0) break;
      cnt  = 0;
      done = 0;
      while (!done) begin
        logic [8:0] b;
        b = mq[p].pop_front();
        cnt++;
        done = b[8] || (cnt == MAXB);
        exp_port.push_back(p);
        exp_data.push_back(b[7:0]);
        exp_end.push_back(done);
      end
      last = p;
    end
    model_last = last;
  endtask

  task automatic run_stream(input int max_cycles, input bit timed);
    int idx, cyc, prev_acc, exp_c;
    bit expect_idle, prev_end;
    logic [NP-1:0] exp_rdy;
    build_model();
    acc_port.delete();
    idx = 0; cyc = 0; prev_acc = -1; prev_end = 1; expect_idle = 0;
    while ((idx < exp_port.size() || expect_idle) && cyc < max_cycles) begin
      drive_inputs(cyc);
      @(negedge clk);
      if (expect_idle) begin
        tests_run++;
        if (busy !== 1'b0) begin
          failed++;
          $display("FAIL idle_gap: busy=%0b expected 0 at cycle %0d", busy, cyc);
        end
        expect_idle = 0;
      end
      if (busy !== 1'b1) begin
        tests_run++;
        if (m_tvalid !== 1'b0 || s_tready !== '0) begin
          failed++;
          $display("FAIL idle_outputs: m_tvalid=%0b s_tready=%b expected 0/0000", m_tvalid,
                   s_tready);
        end
      end else if (idx >= exp_port.size()) begin
        tests_run++;
        failed++;
        $display("FAIL extra_grant: busy=1 grant_id=%0d expected no grant", grant_id);
      end else begin
        int p;
        p = exp_port[idx];
        tests_run++;
        if (grant_id !== IDW'(p)) begin
          failed++;
          $display("FAIL grant_id: got %0d expected %0d (beat %0d)", grant_id, p, idx);
        end
        exp_rdy    = '0;
        exp_rdy[p] = m_tready;
        tests_run++;
        if (s_tready !== exp_rdy) begin
          failed++;
          $display("FAIL s_tready: got %b expected %b", s_tready, exp_rdy);
        end
        tests_run++;
        if (m_tvalid !== s_tvalid[p]) begin
          failed++;
          $display("FAIL tvalid_copy: got %0b expected %0b", m_tvalid, s_tvalid[p]);
        end
        if (m_tvalid === 1'b1) begin
          tests_run++;
          if (m_tdata !== exp_data[idx]) begin
            failed++;
            $display("FAIL data: got %02h expected %02h (beat %0d)", m_tdata, exp_data[idx], idx);
          end
          if (m_tready) begin
            acc_port.push_back(int'(grant_id));
            if (timed) begin
              exp_c = prev_acc + (prev_end ? 2 : 1);
              tests_run++;
              if (cyc != exp_c) begin
                failed++;
                $display("FAIL beat_timing: beat %0d at cycle %0d expected cycle %0d", idx, cyc,
                         exp_c);
              end
            end
            prev_acc    = cyc;
            prev_end    = exp_end[idx];
            expect_idle = exp_end[idx];
            idx++;
          end
        end
      end
      for (int i = 0; i < NP; i++) begin
        if (s_tready[i] && s_tvalid[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    if (idx < exp_port.size()) begin
      tests_run++;
      failed++;
      $display("FAIL timeout: %0d beats seen expected %0d", idx, exp_port.size());
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    s_tvalid = '1;
    s_tlast  = '1;
    s_tdata  = '1;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    tests_run++;
    if (grant_id !== '0) begin
      failed++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id);
    end
    tests_run++;
    if (m_tvalid !== 1'b0) begin
      failed++; $display("FAIL reset_m_tvalid: got %0b expected 0", m_tvalid);
    end
    tests_run++;
    if (s_tready !== '0) begin
      failed++; $display("FAIL reset_s_tready: got %b expected 0000", s_tready);
    end
    apply_reset();
  endtask

  task automatic test_single_port();
    apply_reset();
    ready_mode = 0; drop_en = 0;
    src_q[2].push_back(9'h041);
    src_q[2].push_back(9'h042);
    src_q[2].push_back(9'h143);
    run_stream(20, 1);
    tests_run++;
    if (acc_port.size() != 3) begin
      failed++; $display("FAIL single_port_count: got %0d expected 3", acc_port.size());
    end
  endtask

  task automatic test_all_ports();
    apply_reset();
    ready_mode = 0; drop_en = 0;
    for (int i = 0; i < NP; i++) src_q[i].push_back({1'b1, 8'($urandom)});
    run_stream(30, 1);
    for (int k = 0; k < NP; k++) begin
      tests_run++;
      if (k >= acc_port.size() || acc_port[k] != k) begin
        failed++;
        $display("FAIL all_ports_order: slot %0d got %0d expected %0d", k,
                 (k < acc_port.size()) ? acc_port[k] : -1, k);
      end
    end
  endtask

  task automatic test_burst_limit();
    int order[8];
    order = '{1, 1, 1, 1, 3, 3, 1, 1};
    apply_reset();
    ready_mode = 0; drop_en = 0;
    for (int b = 0; b < 6; b++) src_q[1].push_back({(b == 5), 8'(8'h10 + b)});
    src_q[3].push_back(9'h030);
    src_q[3].push_back(9'h131);
    run_stream(40, 1);
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (k >= acc_port.size() || acc_port[k] != order[k]) begin
        failed++;
        $display("FAIL burst_order: slot %0d got %0d expected %0d", k,
                 (k < acc_port.size()) ? acc_port[k] : -1, order[k]);
      end
    end
  endtask

  task automatic test_ready_toggle();
    apply_reset();
    ready_mode = 1; drop_en = 0;
    for (int b = 0; b < 4; b++) src_q[0].push_back({(b == 3), 8'($urandom)});
    run_stream(40, 0);
    tests_run++;
    if (acc_port.size() != 4) begin
      failed++; $display("FAIL toggle_count: got %0d expected 4", acc_port.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    int acc, cyc;
    apply_reset();
    ready_mode = 0; drop_en = 0;
    for (int b = 0; b < 5; b++) src_q[1].push_back({(b == 4), 8'(8'h60 + b)});
    acc = 0; cyc = 0;
    while (acc < 2 && cyc < 20) begin
      drive_inputs(cyc);
      @(negedge clk);
      if (m_tvalid && m_tready) acc++;
      for (int i = 0; i < NP; i++)
        if (s_tready[i] && s_tvalid[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    tests_run++;
    if (acc != 2) begin failed++; $display("FAIL rst_mid_setup: beats %0d expected 2", acc); end
    src_q[0].push_back(9'h155);
    rst = 1'b1;
    ready_mode = 3;
    drive_inputs(0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    drive_inputs(0);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_idle: busy=%0b m_tvalid=%0b expected 0/0", busy, m_tvalid);
    end
    @(posedge clk);
    #1;
    drive_inputs(1);
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b1 || grant_id !== '0) begin
      failed++;
      $display("FAIL rst_mid_regrant: busy=%0b grant_id=%0d expected 1/0", busy, grant_id);
    end
    tests_run++;
    if (m_tdata !== 8'h55) begin
      failed++; $display("FAIL rst_mid_data: got %02h expected 55", m_tdata);
    end
    @(posedge clk);
    #1;
    apply_reset();
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      bit timed;
      timed      = (it % 3 == 0);
      ready_mode = timed ? 0 : 2;
      drop_en    = timed ? 1'b0 : 1'($urandom);
      src_q[$urandom_range(0, NP-1)].push_back({1'b1, 8'($urandom)});
      for (int p = 0; p < NP; p++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int k = 0; k < npk; k++) begin
          int len;
          len = $urandom_range(1, 7);
          for (int b = 0; b < len; b++) src_q[p].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      run_stream(3000, timed);
    end
  endtask

  initial begin
    ready_mode = 0;
    drop_en    = 0;
    test_reset();
    test_single_port();
    test_all_ports();
    test_burst_limit();
    test_ready_toggle();
    test_reset_mid_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
